// File: rtl/prog_loader_if.sv
// Stream input and memory write/read port of the program loader.
interface prog_loader_if;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        WE;
   logic [31:0] A;
   logic [31:0] WD;
   logic [31:0] RD;

   modport master (
      input  s_valid, s_data, RD,
      output s_ready, WE, A, WD
   );

   modport slave (
      output s_valid, s_data, RD,
      input  s_ready, WE, A, WD
   );
endinterface

// File: rtl/prog_loader.sv
// Streams words into a memory, reads them back and signs both passes;
// holds the core in reset until the readback verifies clean.
module prog_loader #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] ADDR_STEP = 32'd4,
   parameter logic [31:0] BASE      = 32'd0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [10:0]  len,
   prog_loader_if.master bus,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic         err,
   output logic [31:0]  fail_addr,
   output logic         core_rst
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

   state_t      state, nxt;
   logic [10:0] len_q;
   logic [10:0] cnt;
   logic [31:0] wr_sig;
   logic [31:0] rd_sig;
   logic [31:0] rd_nxt;
   logic [31:0] addr;
   logic [31:0] fail_q;
   logic        pass_q;
   logic        err_q;
   logic        mis;
   logic        go;
   logic        hs;
   logic        last;
   logic        too_big;
   logic        bad;
   logic [DEPTH-1:0] par;

   assign addr    = BASE + 32'(cnt) * ADDR_STEP;
   assign last    = (cnt == len_q - 11'd1);
   assign too_big = 32'(len) > DEPTH;
   assign go      = start & ((state == IDLE) | (state == DONE));
   assign hs      = (state == LOAD) & bus.s_valid;
   assign rd_nxt  = {rd_sig[30:0], rd_sig[31]} ^ bus.RD;
   // one parity bit per word pins down the first diverging word
   assign bad     = (state == VERIFY) & (par[cnt[AW-1:0]] != ^bus.RD);

   always_comb begin
      nxt         = state;
      bus.s_ready = 1'b0;
      bus.WE      = 1'b0;
      bus.A       = BASE;
      bus.WD      = 32'd0;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               if (too_big || len == 11'd0) nxt = DONE;
               else                         nxt = LOAD;
            end
         end
         LOAD: begin
            bus.s_ready = 1'b1;
            bus.A       = addr;
            bus.WD      = bus.s_data;
            bus.WE      = bus.s_valid;
            if (bus.s_valid && last) nxt = VERIFY;
         end
         VERIFY: begin
            bus.A = addr;
            if (last) nxt = DONE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         len_q  <= 11'd0;
         cnt    <= 11'd0;
         wr_sig <= 32'd0;
         rd_sig <= 32'd0;
         pass_q <= 1'b0;
         err_q  <= 1'b0;
         fail_q <= 32'd0;
         mis    <= 1'b0;
      end else begin
         state <= nxt;
         if (go) begin
            len_q  <= len;
            cnt    <= 11'd0;
            wr_sig <= 32'd0;
            rd_sig <= 32'd0;
            pass_q <= (len == 11'd0);
            err_q  <= too_big;
            fail_q <= 32'd0;
            mis    <= 1'b0;
         end else if (hs) begin
            wr_sig <= {wr_sig[30:0], wr_sig[31]} ^ bus.s_data;
            cnt    <= last ? 11'd0 : cnt + 11'd1;
         end else if (state == VERIFY) begin
            rd_sig <= rd_nxt;
            cnt    <= cnt + 11'd1;
            if (bad && !mis) begin
               mis    <= 1'b1;
               fail_q <= addr;
            end
            if (last) begin
               pass_q <= (rd_nxt == wr_sig) & ~mis & ~bad;
               // even-weight faults only show in the final signature
               if (!mis && !bad && rd_nxt != wr_sig) fail_q <= addr;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (hs) par[cnt[AW-1:0]] <= ^bus.s_data;
   end

   assign busy      = (state == LOAD) | (state == VERIFY);
   assign done      = (state == DONE);
   assign pass      = pass_q;
   assign err       = err_q;
   assign fail_addr = fail_q;
   assign core_rst  = done & pass_q & ~err_q;
endmodule
